// File: rtl/ultrasonic_ranger_pkg.sv
// Shared state encoding, default timing and sensor indices for the four-sensor ultrasonic ranger.
package ultrasonic_pkg;

    typedef enum logic [2:0] {
        GAP,
        TRIG,
        WAIT_RISE,
        MEASURE,
        EVAL
    } state_t;

    localparam int N_SENS = 4;
    localparam int US_PER_CM = 58;

    localparam int DEF_CNT_W        = 16;
    localparam int DEF_TRIG_US      = 10;
    localparam int DEF_ECHO_WAIT_US = 5000;
    localparam int DEF_ECHO_MAX_US  = 30000;
    localparam int DEF_GAP_US       = 10000;
    localparam int DEF_THRESH_US    = 30 * US_PER_CM;
    localparam int DEF_HYST_US      = 2 * US_PER_CM;

    localparam logic [1:0] SENS_FR = 2'd0;
    localparam logic [1:0] SENS_FL = 2'd1;
    localparam logic [1:0] SENS_R  = 2'd2;
    localparam logic [1:0] SENS_L  = 2'd3;

    // A clear flag drops below clr_lvl; an obstacle flag needs set_lvl to become clear again.
    function automatic logic next_flag(input logic        prev,
                                       input int unsigned width,
                                       input int unsigned clr_lvl,
                                       input int unsigned set_lvl);
        return prev ? (width >= clr_lvl) : (width >= set_lvl);
    endfunction

endpackage

// File: rtl/ultrasonic_ranger_if.sv
// Sensor-facing pins plus the flag bus handed to the obstacle-avoidance controller.
interface ultrasonic_ranger_if;
    logic       en;
    logic [3:0] echo;
    logic [3:0] trig;
    logic [3:0] distance_flag;
    logic       flag_valid;
    logic [3:0] sensor_err;

    modport slave (
        input  en,
        input  echo,
        output trig,
        output distance_flag,
        output flag_valid,
        output sensor_err
    );

    modport master (
        output en,
        output echo,
        input  trig,
        input  distance_flag,
        input  flag_valid,
        input  sensor_err
    );
endinterface

// File: rtl/ultrasonic_ranger_echo_sync.sv
// Two-flop synchronizer for the raw echo lines plus a delay register for edge pulses.
// Edge pulses appear two clocks after the pin changes; no backpressure.
module echo_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_echo,
    output logic [W-1:0] o_sync,
    output logic [W-1:0] o_rise,
    output logic [W-1:0] o_fall
);
    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;
    logic [W-1:0] r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_meta <= i_echo;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;
endmodule

// File: rtl/ultrasonic_ranger.sv
// Round-robin HC-SR04 ranger: times echo widths in us and updates per-sensor clear/obstacle flags.
// Flag updates 4 cycles after echo falls; en low stops new shots. ULTRA_HYST_EN adds a hysteresis band.
module ultrasonic_ranger
    import ultrasonic_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int TRIG_US      = DEF_TRIG_US,
    parameter int ECHO_WAIT_US = DEF_ECHO_WAIT_US,
    parameter int ECHO_MAX_US  = DEF_ECHO_MAX_US,
    parameter int GAP_US       = DEF_GAP_US,
    parameter int THRESH_US    = DEF_THRESH_US,
    parameter int HYST_US      = DEF_HYST_US
) (
    input  logic               clk_1m,
    input  logic               rst,
    ultrasonic_ranger_if.slave bus
);
    localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(GAP_US - 1);
    localparam logic [CNT_W-1:0] TRIG_END = CNT_W'(TRIG_US - 1);
    localparam logic [CNT_W-1:0] WAIT_END = CNT_W'(ECHO_WAIT_US - 1);
    localparam logic [CNT_W-1:0] MAX_END  = CNT_W'(ECHO_MAX_US - 1);
    localparam logic [CNT_W-1:0] MAX_W    = CNT_W'(ECHO_MAX_US);
`ifdef ULTRA_HYST_EN
    localparam int SET_US = THRESH_US + HYST_US;
`else
    // Without hysteresis the set level collapses onto the clear level.
    localparam int SET_US = THRESH_US + 0 * HYST_US;
`endif

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_width, w_width_nxt;
    logic [1:0]       r_sel, w_sel_nxt;
    logic             r_tmo, w_tmo_nxt;
    logic [3:0]       r_trig;
    logic [3:0]       r_flag;
    logic [3:0]       r_err;
    logic             r_flag_valid;
    logic [3:0]       w_sync, w_rise, w_fall;
    logic             w_flag_new;

    echo_sync #(.W(N_SENS)) u_echo_sync (
        .clk    (clk_1m),
        .rst    (rst),
        .i_echo (bus.echo),
        .o_sync (w_sync),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_width_nxt = r_width;
        w_tmo_nxt   = r_tmo;
        w_sel_nxt   = r_sel;
        case (r_state)
            GAP: begin
                // Counter parks at the end of the gap until en is high and every echo line is idle.
                if (r_cnt == GAP_END) begin
                    if (bus.en && !(|w_sync)) begin
                        w_state_nxt = TRIG;
                        w_cnt_nxt   = '0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            TRIG: begin
                if (r_cnt == TRIG_END) begin
                    w_state_nxt = WAIT_RISE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            WAIT_RISE: begin
                if (w_rise[r_sel]) begin
                    w_state_nxt = MEASURE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == WAIT_END) begin
                    w_state_nxt = EVAL;
                    w_cnt_nxt   = '0;
                    w_width_nxt = MAX_W;
                    w_tmo_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            MEASURE: begin
                if (w_fall[r_sel]) begin
                    w_state_nxt = EVAL;
                    w_cnt_nxt   = '0;
                    w_width_nxt = r_cnt;
                    w_tmo_nxt   = 1'b0;
                end else if (r_cnt == MAX_END) begin
                    w_state_nxt = EVAL;
                    w_cnt_nxt   = '0;
                    w_width_nxt = MAX_W;
                    w_tmo_nxt   = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            EVAL: begin
                w_state_nxt = GAP;
                w_cnt_nxt   = '0;
                w_sel_nxt   = r_sel + 2'd1;
            end
            default: begin
                w_state_nxt = GAP;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_flag_new = next_flag(r_flag[r_sel], 32'(r_width), THRESH_US, SET_US);

    always_ff @(posedge clk_1m or posedge rst) begin
        if (rst) begin
            r_state      <= GAP;
            r_cnt        <= '0;
            r_width      <= '0;
            r_tmo        <= 1'b0;
            r_sel        <= SENS_FR;
            r_trig       <= 4'b0000;
            r_flag       <= 4'b1111;
            r_err        <= 4'b0000;
            r_flag_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_width      <= w_width_nxt;
            r_tmo        <= w_tmo_nxt;
            r_sel        <= w_sel_nxt;
            r_trig       <= (w_state_nxt == TRIG) ? (4'b0001 << w_sel_nxt) : 4'b0000;
            r_flag_valid <= (r_state == EVAL);
            if (r_state == EVAL) begin
                r_flag[r_sel] <= w_flag_new;
                r_err[r_sel]  <= r_tmo;
            end
        end
    end

    assign bus.trig          = r_trig;
    assign bus.distance_flag = r_flag;
    assign bus.flag_valid    = r_flag_valid;
    assign bus.sensor_err    = r_err;
endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed bench for ultrasonic_ranger with a shortened gap so the whole sequence fits a short run.
module tb_ultrasonic_ranger;
    localparam int GAP_US       = 1000;
    localparam int ECHO_WAIT_US = 5000;
`ifdef ULTRA_HYST_EN
    localparam bit H = 1'b1;
`else
    localparam bit H = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    ultrasonic_ranger_if bus();

    ultrasonic_ranger #(.GAP_US(GAP_US)) dut (
        .clk_1m (clk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int         trig_len   = 0;
    logic [3:0] trig_prev  = 4'b0000;
    int         onehot_bad = 0;
    int         len_bad    = 0;
    int         trig_log[$];

    always @(negedge clk) begin
        if (rst) begin
            trig_len  = 0;
            trig_prev = 4'b0000;
        end else begin
            if ($countones(bus.trig) > 1) onehot_bad++;
            if (bus.trig != 4'b0000) begin
                if (trig_prev == 4'b0000) begin
                    for (int b = 0; b < 4; b++)
                        if (bus.trig[b]) trig_log.push_back(b);
                end
                trig_len++;
            end else if (trig_prev != 4'b0000) begin
                if (trig_len != 10) len_bad++;
                trig_len = 0;
            end
            trig_prev = bus.trig;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_trig(input int s, input int limit, output int cyc);
        cyc = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (bus.trig[s]) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic wait_fv(input int limit, output int cyc);
        cyc = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (bus.flag_valid) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic do_shot(input string tag, input int s, input bit have_trig, input int dly,
                           input int w, input logic [3:0] exp_flag, input logic [3:0] exp_err);
        int c;
        if (!have_trig) begin
            wait_trig(s, GAP_US + 50, c);
            chk({tag, "_trig"}, (c > 0), 1);
        end
        if (w > 0) begin
            step(dly);
            bus.echo[s] = 1'b1;
            step(w);
            bus.echo[s] = 1'b0;
            wait_fv(10, c);
            chk({tag, "_lat"}, c, 4);
        end else begin
            wait_fv(ECHO_WAIT_US + 50, c);
            chk({tag, "_tmo_lat"}, c, 5011);
        end
        chk({tag, "_flag"}, bus.distance_flag, exp_flag);
        chk({tag, "_err"}, bus.sensor_err, exp_err);
        step(1);
        chk({tag, "_fv_once"}, bus.flag_valid, 0);
    endtask

    initial begin
        int c;
        int n_before;
        int order_bad;
        bus.en   = 1'b1;
        bus.echo = 4'b0000;
        rst      = 1'b1;
        step(3);
        chk("rst_trig", bus.trig, 4'b0000);
        chk("rst_flag", bus.distance_flag, 4'b1111);
        chk("rst_fv", bus.flag_valid, 0);
        chk("rst_err", bus.sensor_err, 4'b0000);
        rst = 1'b0;

        do_shot("s0_noecho", 0, 1'b0, 0, 0, 4'b1111, 4'b0001);
        do_shot("s1_1000", 1, 1'b0, 200, 1000, 4'b1101, 4'b0001);
        do_shot("s2_2000", 2, 1'b0, 200, 2000, 4'b1101, 4'b0001);

        // Sensor 3 echo stuck high: saturates, then holds off the next shot.
        wait_trig(3, GAP_US + 50, c);
        chk("s3_stuck_trig", (c > 0), 1);
        step(100);
        bus.echo[3] = 1'b1;
        wait_fv(30100, c);
        chk("s3_sat_lat", c, 30004);
        chk("s3_sat_flag", bus.distance_flag, 4'b1101);
        chk("s3_sat_err", bus.sensor_err, 4'b0001);
        n_before = trig_log.size();
        step(1300);
        chk("stall_no_trig", trig_log.size(), n_before);
        bus.echo[3] = 1'b0;
        wait_trig(0, 10, c);
        chk("stall_release_lat", c, 3);

        do_shot("s0_1000", 0, 1'b1, 200, 1000, 4'b1100, 4'b0000);
        do_shot("s1_1800a", 1, 1'b0, 200, 1800, H ? 4'b1100 : 4'b1110, 4'b0000);
        do_shot("s2_1738", 2, 1'b0, 200, 1738, H ? 4'b1000 : 4'b1010, 4'b0000);
        do_shot("s3_20", 3, 1'b0, 50, 20, H ? 4'b0000 : 4'b0010, 4'b0000);
        do_shot("s0_20", 0, 1'b0, 50, 20, H ? 4'b0000 : 4'b0010, 4'b0000);
        do_shot("s1_1860", 1, 1'b0, 200, 1860, 4'b0010, 4'b0000);
        do_shot("s2_1742", 2, 1'b0, 200, 1742, H ? 4'b0010 : 4'b0110, 4'b0000);
        do_shot("s3_2000", 3, 1'b0, 200, 2000, H ? 4'b1010 : 4'b1110, 4'b0000);
        do_shot("s0_20b", 0, 1'b0, 50, 20, H ? 4'b1010 : 4'b1110, 4'b0000);
        do_shot("s1_1800b", 1, 1'b0, 200, 1800, H ? 4'b1010 : 4'b1110, 4'b0000);

        // en dropped while sensor 2 is in flight: that shot completes, nothing new starts.
        wait_trig(2, GAP_US + 50, c);
        chk("en_off_trig", (c > 0), 1);
        bus.en = 1'b0;
        do_shot("s2_en_off", 2, 1'b1, 50, 20, 4'b1010, 4'b0000);
        n_before = trig_log.size();
        step(1300);
        chk("en_off_no_trig", trig_log.size(), n_before);
        bus.en = 1'b1;
        wait_trig(3, 5, c);
        chk("en_on_lat", c, 1);

        step(50);
        chk("order_count", trig_log.size(), 16);
        order_bad = 0;
        foreach (trig_log[i])
            if (trig_log[i] != (i % 4)) order_bad++;
        chk("order_rr", order_bad, 0);

        // Reset in the middle of a measurement.
        bus.echo[3] = 1'b1;
        step(100);
        rst = 1'b1;
        #1;
        chk("mid_rst_trig", bus.trig, 4'b0000);
        chk("mid_rst_flag", bus.distance_flag, 4'b1111);
        chk("mid_rst_err", bus.sensor_err, 4'b0000);
        chk("mid_rst_fv", bus.flag_valid, 0);
        bus.echo[3] = 1'b0;
        step(3);
        trig_log.delete();
        rst = 1'b0;
        wait_trig(0, GAP_US + 50, c);
        chk("post_rst_trig_lat", c, GAP_US);
        step(20);
        chk("post_rst_first_s0", (trig_log.size() == 1 && trig_log[0] == 0), 1);
        chk("trig_onehot", onehot_bad, 0);
        chk("trig_len10", len_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ultrasonic_ranger.md
Name: ultrasonic_ranger

Overview:
Front end that produces the 4-bit obstacle flag vector consumed by the obstacle-avoidance controller. It drives the trigger pins of four HC-SR04-style ultrasonic sensors in round-robin order and times each echo pulse in microseconds. Each width is compared against a distance threshold, and the result updates a registered per-sensor flag, where 1 = path clear and 0 = obstacle. Bit map, used for both trig and distance_flag: [3] left, [2] right, [1] front-left, [0] front-right.

Parameters:
CNT_W, 16, width of the µs counter. Must hold ECHO_MAX_US.
TRIG_US, 10, trigger pulse width in µs.
ECHO_WAIT_US, 5000, maximum wait for the echo rising edge.
ECHO_MAX_US, 30000, echo width saturation and measurement timeout.
GAP_US, 10000, idle time between consecutive sensor shots (crosstalk guard).
THRESH_US, 1740, echo width at or above which a sensor reads clear (about 30 cm at 58 µs/cm).
HYST_US, 116, hysteresis band. Used only with ULTRA_HYST_EN.

Ports:
clk_1m  in  1  1 MHz clock; one cycle = 1 µs.
rst  in  1  asynchronous, active-high reset.
en  in  1  when low, no new shot starts; a measurement already in flight completes.
echo  in  4  raw echo lines, asynchronous to clk_1m.
trig  out  4  trigger outputs, at most one bit high at a time.
distance_flag  out  4  registered per-sensor flag; 1 = clear, 0 = obstacle.
flag_valid  out  1  one-cycle pulse each time any flag bit is re-evaluated.
sensor_err  out  4  set on no-echo timeout; cleared on the next good measurement of that sensor.

Behaviour:
- Reset values:
  - trig = 0, distance_flag = 4'b1111 (controller drives straight), flag_valid = 0, sensor_err = 0.
  - Sensor index sel = 0, state = GAP with the counter cleared.
  - Reset is asynchronous: trig drops in the same instant, including mid-shot.
- Echo path: each bit of echo passes through a 2-FF synchronizer, plus one register for edge detection. Rise/fall detection therefore lags the pin by 2 cycles.
- The state machine handles one sensor at a time (sel). The µs counter cnt clears on every state entry.
  - GAP: wait until cnt reaches GAP_US-1, en = 1, and all synced echo bits are low. Then go to TRIG. If en is low or any echo is still high, stay in GAP and hold cnt saturated.
  - TRIG: trig[sel] = 1 for exactly TRIG_US cycles, then WAIT_RISE.
  - WAIT_RISE: on a synced rising edge of echo[sel], go to MEASURE with cnt = 0. If cnt reaches ECHO_WAIT_US-1 first, set width = ECHO_MAX_US and the err flag, then go to EVAL.
  - MEASURE: cnt increments each cycle while echo[sel] is high. On a synced falling edge, width = cnt and go to EVAL. If cnt reaches ECHO_MAX_US-1, width saturates at ECHO_MAX_US and the FSM goes to EVAL without waiting for the fall.
  - EVAL (1 cycle):
    - Update distance_flag[sel].
    - Update sensor_err[sel]: set on a WAIT_RISE timeout, otherwise clear.
    - Pulse flag_valid.
    - Advance sel = (sel+1) mod 4 (3 wraps to 0), then go to GAP.
- Flag rule without hysteresis: flag = (width >= THRESH_US). A timeout or saturated width reads clear.
- Flag update latency: distance_flag changes in the cycle after EVAL, which is 4 cycles after the echo pin falls.
- Bits not addressed by sel hold their value.
- Comparisons use unsigned CNT_W-bit arithmetic, and cnt never wraps.
- Echo activity on non-selected sensors is ignored, apart from the GAP idle check.

Optional Feature:
Macro ULTRA_HYST_EN.
- Defined: a flag currently 1 clears only when width < THRESH_US; a flag currently 0 sets only when width >= THRESH_US+HYST_US. Widths inside the band keep the previous value.
- Undefined: the single-threshold rule above applies, and HYST_US is unused.

Decomposition:
- Package ultrasonic_pkg holds:
  - the state enum (GAP, TRIG, WAIT_RISE, MEASURE, EVAL);
  - default timing constants;
  - US_PER_CM = 58;
  - sensor index constants SENS_FR = 0, SENS_FL = 1, SENS_R = 2, SENS_L = 3.
- One sub-module, echo_sync: a 4-bit 2-FF synchronizer with registered rise/fall pulses.

Test Plan:
- Sensor 1 echo rises 200 µs after trig, width 1000 µs, prior flag 1 -> distance_flag[1] = 0, flag_valid pulses once, sensor_err[1] = 0.
- Sensor 2 echo width 2000 µs -> distance_flag[2] = 1.
- Sensor 0 gets no echo -> WAIT_RISE times out at 5000 µs, distance_flag[0] = 1 and sensor_err[0] = 1. A following 1000 µs shot gives sensor_err[0] = 0 and flag 0.
- Echo[3] held high permanently -> MEASURE ends at 30000 µs with flag 1. GAP then stalls and no trig asserts until echo[3] falls.
- Free-run with en = 1 -> the trig order is 0,1,2,3,0, each pulse exactly 10 cycles and never two bits high at once. With en = 0 there is no trig after the current EVAL.
- Assert rst mid-MEASURE -> trig = 0 and distance_flag = 1111 immediately; after release, the first trig goes to sensor 0 once GAP_US has elapsed.
- With ULTRA_HYST_EN and flag[1] = 0: width 1800 -> flag stays 0; width 1860 -> flag = 1; width 1800 again -> flag stays 1.
